array_packer: RTL and testbench

ARRAY_PACKER -- requirements
Module: array_packer

---
 rtl/array_packer_pkg.sv | 12 +
 rtl/array_packer.sv | 110 +++++++++++
 tb/tb_array_packer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/array_packer_pkg.sv
// Shared types and default sizing for the array packer.
package array_packer_types;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DEPTH = 2;

   typedef enum logic {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

endpackage

// File: rtl/array_packer.sv
// Packs a stream of signed elements into DEPTH-wide arrays, with flush for partial arrays.
// Optional running sum output enabled by defining ARRAY_PACKER_SUM_EN.
module array_packer
   import array_packer_types::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic signed [WIDTH-1:0]                b_in,
   input  logic                                   b_in_sync,
   output logic                                   b_in_notify,
   input  logic                                   flush,
   output logic signed [WIDTH-1:0]                b_out [DEPTH],
   output logic        [$clog2(DEPTH+1)-1:0]      b_out_len,
   input  logic                                   b_out_sync,
   output logic                                   b_out_notify
`ifdef ARRAY_PACKER_SUM_EN
   ,
   output logic signed [WIDTH+$clog2(DEPTH)-1:0]  b_out_sum
`endif
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
`ifdef ARRAY_PACKER_SUM_EN
   localparam int unsigned SW = WIDTH + $clog2(DEPTH);
`endif

   state_e          r_state;
   state_e          w_state_nxt;
   logic [CW-1:0]   r_count;
   logic            w_accept;
   logic            w_release;

   assign b_out_len = r_count;

   // Next-state and handshake decode.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         COLLECT: begin
            w_accept = b_in_notify && b_in_sync;
            if (w_accept && (r_count == CW'(DEPTH - 1))) begin
               w_state_nxt = EMIT;
            end else if (flush && (w_accept || (r_count != '0))) begin
               w_state_nxt = EMIT;
            end
         end
         EMIT: begin
            w_release = b_out_notify && b_out_sync;
            if (w_release) begin
               w_state_nxt = COLLECT;
            end
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   // State register; notify flags are registered decodes of the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= COLLECT;
         b_in_notify  <= 1'b1;
         b_out_notify <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         b_in_notify  <= (w_state_nxt == COLLECT);
         b_out_notify <= (w_state_nxt == EMIT);
      end
   end

   // Element storage and fill count; cleared on reset and after each output transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            b_out[i] <= '0;
         end
      end else if (w_release) begin
         r_count <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            b_out[i] <= '0;
         end
      end else if (w_accept) begin
         r_count <= r_count + CW'(1);
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_count == CW'(i)) begin
               b_out[i] <= b_in;
            end
         end
      end
   end

`ifdef ARRAY_PACKER_SUM_EN
   // Running sign-extended sum, wide enough that DEPTH elements never overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b_out_sum <= '0;
      end else if (w_release) begin
         b_out_sum <= '0;
      end else if (w_accept) begin
         b_out_sum <= b_out_sum + SW'(b_in);
      end
   end
`endif

endmodule

// File: tb/tb_array_packer.sv
// Directed bench for array_packer: one DEPTH=2/WIDTH=8 instance and one DEPTH=4/WIDTH=32 instance.
module tb_array_packer;

   logic clk;
   logic rst;

   logic signed [7:0]  i2;
   logic               s2, f2, os2;
   logic               in_n2, on2;
   logic signed [7:0]  bo2 [2];
   logic [1:0]         len2;
`ifdef ARRAY_PACKER_SUM_EN
   logic signed [8:0]  sum2;
   logic signed [33:0] sum4;
`endif

   logic signed [31:0] i4;
   logic               s4, f4, os4;
   logic               in_n4, on4;
   logic signed [31:0] bo4 [4];
   logic [2:0]         len4;

   int n_total = 0;
   int n_pass  = 0;

   array_packer #(.WIDTH(8), .DEPTH(2)) u_d2 (
      .clk          (clk),
      .rst          (rst),
      .b_in         (i2),
      .b_in_sync    (s2),
      .b_in_notify  (in_n2),
      .flush        (f2),
      .b_out        (bo2),
      .b_out_len    (len2),
      .b_out_sync   (os2),
      .b_out_notify (on2)
`ifdef ARRAY_PACKER_SUM_EN
      ,
      .b_out_sum    (sum2)
`endif
   );

   array_packer #(.WIDTH(32), .DEPTH(4)) u_d4 (
      .clk          (clk),
      .rst          (rst),
      .b_in         (i4),
      .b_in_sync    (s4),
      .b_in_notify  (in_n4),
      .flush        (f4),
      .b_out        (bo4),
      .b_out_len    (len4),
      .b_out_sync   (os4),
      .b_out_notify (on4)
`ifdef ARRAY_PACKER_SUM_EN
      ,
      .b_out_sum    (sum4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      i2 = '0; s2 = 1'b0; f2 = 1'b0; os2 = 1'b0;
      i4 = '0; s4 = 1'b0; f4 = 1'b0; os4 = 1'b0;
      step();
      step();
      check("rst_in_notify", in_n2, 1);
      check("rst_out_notify", on2, 0);
      check("rst_len", len2, 0);
      check("rst_b0", bo2[0], 0);
      check("rst_len4", len4, 0);
      rst = 1'b0;

      // DEPTH=2 streaming: 5, -3 then 11, 12 with consumer always ready
      i2 = 8'sd5; s2 = 1'b1; os2 = 1'b1;
      step();
      check("a_collect_mid", on2, 0);
      i2 = -8'sd3;
      step();
      check("a_out_notify", on2, 1);
      check("a_in_notify", in_n2, 0);
      check("a_len", len2, 2);
      check("a_b0", bo2[0], 5);
      check("a_b1", bo2[1], -3);
      i2 = 8'sd11;
      step();
      check("a_notify_one_cycle", on2, 0);
      check("a_cleared_len", len2, 0);
      check("a_cleared_b0", bo2[0], 0);
      step();
      check("a_second_accept", len2, 1);
      i2 = 8'sd12;
      step();
      check("a_period3_notify", on2, 1);
      check("a2_b0", bo2[0], 11);
      check("a2_b1", bo2[1], 12);
      s2 = 1'b0;
      step();
      check("a2_released", on2, 0);

      // Back-pressure: array held while producer keeps offering 9
      os2 = 1'b0; s2 = 1'b1; i2 = 8'sd20;
      step();
      i2 = 8'sd21;
      step();
      i2 = 8'sd9;
      for (int k = 0; k < 5; k++) begin
         step();
         check("d_hold_b0", bo2[0], 20);
         check("d_hold_b1", bo2[1], 21);
         check("d_hold_in_notify", in_n2, 0);
         check("d_hold_out_notify", on2, 1);
      end
      os2 = 1'b1;
      step();
      check("d_release_len", len2, 0);
      check("d_release_b0", bo2[0], 0);
      os2 = 1'b0;
      step();
      check("d_after_len", len2, 1);
      check("d_after_b0", bo2[0], 9);
      s2 = 1'b0;

      // Mid-operation reset discards the partial array
      rst = 1'b1;
      #1;
      check("e_rst_len", len2, 0);
      check("e_rst_b0", bo2[0], 0);
      check("e_rst_in_notify", in_n2, 1);
      step();
      rst = 1'b0;
      i2 = 8'sd4; s2 = 1'b1;
      step();
      i2 = 8'sd6;
      step();
      s2 = 1'b0;
      check("e_len", len2, 2);
      check("e_b0", bo2[0], 4);
      check("e_b1", bo2[1], 6);
      os2 = 1'b1;
      step();
      check("e_release", on2, 0);
      os2 = 1'b0;

      // DEPTH=4: accept 7 then flush alone
      i4 = 32'sd7; s4 = 1'b1;
      step();
      s4 = 1'b0; f4 = 1'b1;
      step();
      f4 = 1'b0;
      check("b_out_notify", on4, 1);
      check("b_len", len4, 1);
      check("b_b0", bo4[0], 7);
      check("b_b1", bo4[1], 0);
      check("b_b3", bo4[3], 0);
      os4 = 1'b1;
      step();
      check("b_release_len", len4, 0);
      os4 = 1'b0;

      // Flush with an empty array does nothing
      f4 = 1'b1;
      step();
      f4 = 1'b0;
      check("z_flush_empty_notify", on4, 0);
      check("z_flush_empty_in", in_n4, 1);

      // Element and flush in the same cycle
      i4 = 32'sd1; s4 = 1'b1;
      step();
      i4 = 32'sd2;
      step();
      i4 = 32'sd3; f4 = 1'b1;
      step();
      s4 = 1'b0;
      check("c_len", len4, 3);
      check("c_b0", bo4[0], 1);
      check("c_b1", bo4[1], 2);
      check("c_b2", bo4[2], 3);
      check("c_b3", bo4[3], 0);
      // Flush during EMIT must be ignored
      step();
      f4 = 1'b0;
      check("c_flush_in_emit_len", len4, 3);
      check("c_flush_in_emit_notify", on4, 1);
      os4 = 1'b1;
      step();
      check("c_release", on4, 0);
      os4 = 1'b0;

      // Full DEPTH=4 array
      s4 = 1'b1;
      i4 = 32'sd10; step();
      i4 = 32'sd20; step();
      i4 = 32'sd30; step();
      check("f_not_yet", on4, 0);
      i4 = -32'sd40; step();
      check("f_len", len4, 4);
      check("f_b3", bo4[3], -40);
      check("f_b0", bo4[0], 10);
      os4 = 1'b1;
      step();
      s4 = 1'b0;
      check("f_release_len", len4, 0);
      check("f_release_in", in_n4, 1);
      os4 = 1'b0;

`ifdef ARRAY_PACKER_SUM_EN
      // Sum grows wide enough to hold 127+127
      i2 = 8'sd127; s2 = 1'b1;
      step();
      step();
      s2 = 1'b0;
      check("s_sum", sum2, 254);
      check("s_len", len2, 2);
      os2 = 1'b1;
      step();
      check("s_sum_clear", sum2, 0);
      os2 = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
